conv_frame_sequencer: RTL and testbench
=======================================

# conv_frame_sequencer

Controller that sequences one or more `conv_layer` instances fed from a shared `double_fifo`. It watches the write handshake into that FIFO and counts accepted words. When a full input frame is buffered, it pulses `start_i` to every convolution unit. It then waits for all units to report `valid_o`, presents a single frame-done handshake downstream, and retires the results by pulsing `yumi_i` to every unit.

## Interface

Parameters:
- `NUM_CONVS`, 2: number of convolution units started in lockstep.
- `FRAME_WORDS`, 8: words per input frame (INPUT_LAYER_HEIGHT*KERNEL_WIDTH of the driven layer); must be ≥ 2.
- `TIMEOUT_CYCLES`, 256: watchdog limit, in cycles, for the RUN state; used only when the watchdog is compiled in.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `fifo_wen_i` input 1: write strobe into the shared FIFO (serializer `wen_o`).
- `fifo_full_i` input 1: FIFO `full_o`; a word is accepted when `fifo_wen_i & ~fifo_full_i`.
- `conv_start_o` output NUM_CONVS: start pulse, identical on all bits.
- `conv_valid_i` input NUM_CONVS: `valid_o` of each conv unit.
- `conv_yumi_o` output NUM_CONVS: `yumi_i` to each conv unit, identical on all bits.
- `valid_o` output 1: all unit outputs for the current frame are valid.
- `ready_i` input 1: downstream accepts the frame.
- `busy_o` output 1: state is not IDLE.
- `frames_done_o` output 16: count of retired frames; wraps modulo 2^16.
- `overflow_o` output 1: sticky; a frame completed while the pending count was saturated.
- `error_o` output 1: sticky watchdog error.

## Operation

Word counter `wcnt`, range 0..FRAME_WORDS-1:
- Increments on every accepted write, in any state, including ERR.
- On an accepted write while `wcnt == FRAME_WORDS-1`, `wcnt` wraps to 0 and a frame completes.

Pending-frame counter `pend`, 2 bits, saturates at 3:
- +1 on frame completion.
- −1 on a downstream handshake (`valid_o & ready_i`).
- Both in the same cycle: `pend` is unchanged.
- A frame completion while `pend == 3` and no handshake occurs sets `overflow_o`; `pend` stays at 3.

Done mask `dmask`, NUM_CONVS bits:
- In RUN, `dmask <= dmask | conv_valid_i`.
- Cleared on entry to START.

States:
- IDLE: go to START when `pend != 0`.
- START: `conv_start_o` is all ones for exactly this one cycle; go to RUN.
- RUN: go to OUT when `(dmask | conv_valid_i)` is all ones.
- OUT: `valid_o = 1`. When `ready_i` is high, `conv_yumi_o` is all ones in that same cycle (combinational), `frames_done_o` increments, and the next state is START if `pend` after the decrement (including any same-cycle increment) is nonzero, otherwise IDLE.
- ERR: reachable only with the watchdog compiled in. Terminal until reset. All start and yumi outputs are 0; `busy_o = 1`.

Output decoding:
- All outputs are Moore except `conv_yumi_o`, which is `{NUM_CONVS{state==OUT & ready_i}}`.
- `busy_o = (state != IDLE)`.

Reset values:
- State IDLE; `wcnt`, `pend`, `dmask` and `frames_done_o` are 0.
- Every output is 0.
- Reset asserted mid-frame discards the partial word count and any in-flight frame immediately (asynchronously).

## Timing

- The frame-completing write is accepted at edge k. Then `pend = 1` after edge k, START runs in cycle k+1 (so `conv_start_o` is high for cycle k+1 only), and RUN begins at edge k+2.
- If `conv_valid_i` is all ones in RUN cycle m, then `valid_o` rises after edge m.
- A handshake in OUT cycle h, with `pend` still nonzero afterwards, gives START in cycle h+1. Back-to-back frames therefore have no IDLE gap.
- Minimum START-to-START spacing is 3 cycles (START, RUN, OUT).
- `conv_valid_i` bits may arrive in different cycles. Each bit is captured once and need not stay high.

## Configuration

`CONV_SEQ_WATCHDOG_EN`:
- Defined: a 16-bit cycle counter clears on entering RUN and increments each RUN cycle. If it reaches TIMEOUT_CYCLES before the RUN→OUT condition, the next state is ERR and `error_o` is set. The RUN→OUT condition takes priority when both occur in the same cycle.
- Undefined: no counter and no ERR state; `error_o` is tied to 0.

## Test plan

1. FRAME_WORDS=8, 8 accepted writes with no full stall: one `conv_start_o` pulse (value 2'b11) in the cycle after the 8th write; `busy_o=1`.
2. `conv_valid_i` = 01, then 00, then 10 on successive cycles: `valid_o` rises after the third cycle's edge; holding `ready_i=0` for 5 cycles keeps `valid_o=1` and `conv_yumi_o=0`; then `ready_i=1` gives `conv_yumi_o=2'b11` for one cycle and `frames_done_o=1`.
3. 16 writes burst during RUN: `pend` reaches 2; after the first handshake, START follows the next cycle with no IDLE gap; after the second handshake the block returns to IDLE with `frames_done_o=2`.
4. `fifo_wen_i=1` with `fifo_full_i=1` for 4 cycles: `wcnt` does not advance and no start pulse occurs.
5. 32 writes while the unit never asserts valid: `overflow_o=1` on the 4th frame completion and `pend` stays at 3; drop `reset_n_i` mid-run: all outputs are 0 immediately, without waiting for a clock edge.
6. With `CONV_SEQ_WATCHDOG_EN`, TIMEOUT_CYCLES=10 and no `conv_valid_i`: `error_o=1` after 10 RUN cycles, then no further start pulses even with `pend > 0`.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: counts words written into the shared FIFO, starts all conv units
// per buffered frame, and retires results through one downstream handshake.
// Optional RUN-state watchdog is enabled by defining CONV_SEQ_WATCHDOG_EN.
module conv_frame_sequencer #(
   parameter int unsigned NUM_CONVS      = 2,
   parameter int unsigned FRAME_WORDS    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 fifo_wen_i,
   input  logic                 fifo_full_i,
   output logic [NUM_CONVS-1:0] conv_start_o,
   input  logic [NUM_CONVS-1:0] conv_valid_i,
   output logic [NUM_CONVS-1:0] conv_yumi_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 busy_o,
   output logic [15:0]          frames_done_o,
   output logic                 overflow_o,
   output logic                 error_o
);

   localparam int unsigned WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

   if (FRAME_WORDS < 2 || TIMEOUT_CYCLES == 0) begin : g_param_chk
      $error("conv_frame_sequencer: FRAME_WORDS must be >= 2 and TIMEOUT_CYCLES > 0");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_OUT
`ifdef CONV_SEQ_WATCHDOG_EN
      , S_ERR
`endif
   } state_t;

   state_t                state;
   logic [WCNT_W-1:0]     wcnt;
   logic [1:0]            pend;
   logic [1:0]            pend_nxt_c;
   logic [NUM_CONVS-1:0]  dmask;
   logic                  accept_c;
   logic                  frame_c;
   logic                  hs_c;
   logic                  all_done_c;

   assign accept_c    = fifo_wen_i & ~fifo_full_i;
   assign frame_c     = accept_c & (wcnt == WCNT_W'(FRAME_WORDS - 1));
   assign hs_c        = valid_o & ready_i;
   assign all_done_c  = &(dmask | conv_valid_i);
   assign conv_yumi_o = {NUM_CONVS{(state == S_OUT) & ready_i}};

   // Pending frames saturate at 3; a simultaneous completion and handshake cancel out.
   always_comb begin
      pend_nxt_c = pend;
      case ({frame_c, hs_c})
         2'b10:   if (pend != 2'd3) pend_nxt_c = pend + 2'd1;
         2'b01:   pend_nxt_c = pend - 2'd1;
         default: pend_nxt_c = pend;
      endcase
   end

`ifdef CONV_SEQ_WATCHDOG_EN
   logic [15:0] wd_cnt;
   logic        wd_trip_c;

   assign wd_trip_c = (state == S_RUN) & ~all_done_c & (wd_cnt >= 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wd_cnt  <= '0;
         error_o <= 1'b0;
      end else begin
         if (state == S_START)    wd_cnt <= '0;
         else if (state == S_RUN) wd_cnt <= wd_cnt + 16'd1;
         if (wd_trip_c)           error_o <= 1'b1;
      end
   end
`else
   assign error_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state         <= S_IDLE;
         wcnt          <= '0;
         pend          <= '0;
         dmask         <= '0;
         conv_start_o  <= '0;
         valid_o       <= 1'b0;
         busy_o        <= 1'b0;
         frames_done_o <= '0;
         overflow_o    <= 1'b0;
      end else begin
         wcnt         <= frame_c ? '0 : (accept_c ? wcnt + WCNT_W'(1) : wcnt);
         pend         <= pend_nxt_c;
         conv_start_o <= '0;
         if (frame_c & ~hs_c & (pend == 2'd3)) overflow_o <= 1'b1;

         case (state)
            S_IDLE: begin
               if (pend != 2'd0) begin
                  state        <= S_START;
                  conv_start_o <= '1;
                  busy_o       <= 1'b1;
                  dmask        <= '0;
               end
            end
            S_START: state <= S_RUN;
            S_RUN: begin
               dmask <= dmask | conv_valid_i;
               if (all_done_c) begin
                  state   <= S_OUT;
                  valid_o <= 1'b1;
               end
`ifdef CONV_SEQ_WATCHDOG_EN
               else if (wd_trip_c) begin
                  state <= S_ERR;
               end
`endif
            end
            S_OUT: begin
               if (ready_i) begin
                  frames_done_o <= frames_done_o + 16'd1;
                  valid_o       <= 1'b0;
                  if (pend_nxt_c != 2'd0) begin
                     state        <= S_START;
                     conv_start_o <= '1;
                     dmask        <= '0;
                  end else begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                  end
               end
            end
`ifdef CONV_SEQ_WATCHDOG_EN
            S_ERR: state <= S_ERR;
`endif
            default: begin
               state   <= S_IDLE;
               valid_o <= 1'b0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer; retired frames are scoreboarded
// against the frame completions the bench drives.
module tb_conv_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_wen, fifo_full;
   logic [1:0]  conv_start, conv_valid, conv_yumi;
   logic        valid, ready, busy, overflow, error;
   logic [15:0] frames_done;

   int          n_chk = 0;
   int          n_fail = 0;
   int          start_cnt = 0;
   int          push_idx = 0;
   int          m_wcnt = 0;
   int          s0;
   int          sb[$];

   always #5 clk = ~clk;

   conv_frame_sequencer #(
      .NUM_CONVS(2), .FRAME_WORDS(8), .TIMEOUT_CYCLES(10)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .fifo_wen_i(fifo_wen), .fifo_full_i(fifo_full),
      .conv_start_o(conv_start), .conv_valid_i(conv_valid), .conv_yumi_o(conv_yumi),
      .valid_o(valid), .ready_i(ready), .busy_o(busy),
      .frames_done_o(frames_done), .overflow_o(overflow), .error_o(error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One accepted write; frame completions push the expected retire count.
   task automatic write_word();
      fifo_wen = 1'b1;
      @(posedge clk);
      if (!fifo_full) begin
         m_wcnt++;
         if (m_wcnt == 8) begin
            m_wcnt = 0;
            if (sb.size() < 3) begin
               push_idx++;
               sb.push_back(push_idx);
            end
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      fifo_wen = 1'b0; fifo_full = 1'b0; conv_valid = '0; ready = 1'b0;
      sb.delete(); push_idx = 0; m_wcnt = 0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!valid && k < 20) begin
         step(1);
         k++;
      end
      check(tag, 32'(valid), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_valid"}, 32'(valid), 0);
      check({tag, "_start"}, 32'(conv_start), 0);
      check({tag, "_yumi"}, 32'(conv_yumi), 0);
      check({tag, "_frames_done"}, 32'(frames_done), 0);
      check({tag, "_overflow"}, 32'(overflow), 0);
      check({tag, "_error"}, 32'(error), 0);
   endtask

   // Monitor: start pulses and downstream handshakes, checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (conv_start != 2'b00) begin
            start_cnt++;
            check("start_all_bits", 32'(conv_start), 32'h3);
         end
         if (valid && ready) begin
            if (sb.size() == 0) check("sb_unexpected_handshake", 1, 0);
            else begin
               int exp_fd;
               exp_fd = sb.pop_front();
               check("sb_frames_done", 32'(16'(frames_done + 16'd1)), 32'(exp_fd));
               check("sb_yumi", 32'(conv_yumi), 32'h3);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; fifo_wen = 1'b0; fifo_full = 1'b0; conv_valid = '0; ready = 1'b0;
      #3;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1);

      // Single frame start after the eighth write
      for (int i = 0; i < 8; i++) write_word();
      fifo_wen = 1'b0;
      check("t1_no_early_start", 32'(conv_start), 0);
      check("t1_still_idle", 32'(busy), 0);
      step();
      check("t1_start", 32'(conv_start), 32'h3);
      check("t1_busy", 32'(busy), 1);
      step();
      check("t1_start_one_cycle", 32'(conv_start), 0);

      // Staggered valids, downstream stall, then retire
      conv_valid = 2'b01; step();
      check("t2_partial_a", 32'(valid), 0);
      conv_valid = 2'b00; step();
      check("t2_partial_b", 32'(valid), 0);
      conv_valid = 2'b10; step();
      check("t2_valid", 32'(valid), 1);
      conv_valid = 2'b00;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_hold_valid", 32'(valid), 1);
         check("t2_no_yumi", 32'(conv_yumi), 0);
      end
      ready = 1'b1; #1;
      check("t2_yumi", 32'(conv_yumi), 32'h3);
      step(); ready = 1'b0;
      check("t2_frames_done", 32'(frames_done), 1);
      check("t2_idle", 32'(busy), 0);
      check("t2_sb_empty", 32'(sb.size()), 0);

      // Back-to-back frames with no IDLE gap
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         write_word();
         if (i == 8) check("t3_start_in_burst", 32'(conv_start), 32'h3);
      end
      fifo_wen = 1'b0;
      conv_valid = 2'b11; step();
      check("t3_out", 32'(valid), 1);
      conv_valid = 2'b00; ready = 1'b1; step(); ready = 1'b0;
      check("t3_b2b_start", 32'(conv_start), 32'h3);
      check("t3_no_gap", 32'(busy), 1);
      check("t3_fd1", 32'(frames_done), 1);
      step();
      conv_valid = 2'b11; step();
      check("t3_out2", 32'(valid), 1);
      conv_valid = 2'b00; ready = 1'b1; step(); ready = 1'b0;
      check("t3_idle", 32'(busy), 0);
      check("t3_fd2", 32'(frames_done), 2);
      check("t3_no_restart", 32'(conv_start), 0);
      step();
      check("t3_stay_idle", 32'(busy), 0);
      check("t3_sb_empty", 32'(sb.size()), 0);

      // Writes blocked by a full FIFO do not count
      apply_reset();
      s0 = start_cnt;
      fifo_full = 1'b1; fifo_wen = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_stall_idle", 32'(busy), 0);
      end
      fifo_full = 1'b0;
      for (int i = 0; i < 7; i++) write_word();
      fifo_wen = 1'b0; step();
      check("t4_no_frame_yet", 32'(busy), 0);
      check("t4_no_start", 32'(start_cnt - s0), 0);
      write_word(); fifo_wen = 1'b0; step();
      check("t4_frame_start", 32'(conv_start), 32'h3);
      step();
      conv_valid = 2'b11; step();
      conv_valid = 2'b00; ready = 1'b1; step(); ready = 1'b0;
      check("t4_fd", 32'(frames_done), 1);

      // Pending saturation, overflow, and asynchronous reset mid-run
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         write_word();
         if (i == 23) check("t5_no_overflow_yet", 32'(overflow), 0);
      end
      fifo_wen = 1'b0;
      check("t5_overflow", 32'(overflow), 1);
`ifndef CONV_SEQ_WATCHDOG_EN
      conv_valid = 2'b11;
      for (int f = 0; f < 3; f++) begin
         wait_valid("t5_drain_valid");
         ready = 1'b1; step(); ready = 1'b0;
      end
      conv_valid = 2'b00; step();
      check("t5_pend_saturated", 32'(busy), 0);
      check("t5_fd3", 32'(frames_done), 3);
      check("t5_overflow_sticky", 32'(overflow), 1);
`endif
      for (int i = 0; i < 8; i++) write_word();
      fifo_wen = 1'b0; step(2);
      check("t5_running", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      sb.delete(); push_idx = 0; m_wcnt = 0;
      #1;
      check_all_zero("t5_async_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();

`ifdef CONV_SEQ_WATCHDOG_EN
      // Watchdog trips after TIMEOUT_CYCLES RUN cycles and is terminal
      apply_reset();
      for (int i = 0; i < 8; i++) write_word();
      fifo_wen = 1'b0; step(2);
      step(9);
      check("t6_no_error_yet", 32'(error), 0);
      step();
      check("t6_error", 32'(error), 1);
      check("t6_busy", 32'(busy), 1);
      s0 = start_cnt;
      for (int i = 0; i < 8; i++) write_word();
      fifo_wen = 1'b0; step(5);
      check("t6_no_more_starts", 32'(start_cnt - s0), 0);
      check("t6_no_valid", 32'(valid), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
